// File: rtl/score_keeper.sv
// score_keeper: per-player point counting, match state machine and score overlay.
//
// Consumes the ball stage's asynchronous point flags, counts points per player,
// runs the PLAY / GAME_OVER / RESTART match sequence, holds the ball in reset
// between matches, renders both scores as 7-segment digits near the top of a
// 640x480 frame and drives two active-low HEX displays.
//
// Ports:
//   clk, reset        pixel clock; asynchronous active-high reset
//   hcount, vcount    current pixel position (10-bit)
//   vsync             VGA vsync, synchronous to clk
//   p1score, p2score  point flags from the ball stage (asynchronous levels)
//   start             serve/restart button (asynchronous, active-high)
//   p1_points         player-1 score, binary
//   p2_points         player-2 score, binary
//   game_over         high while the match is over
//   winner            0 = player 1, 1 = player 2 (valid with game_over)
//   ball_hold         held high between matches; ORed into the ball reset
//   r, g, b           registered score overlay pixel
//   hex_p1, hex_p2    active-low segments {g,f,e,d,c,b,a}
module score_keeper #(
  parameter int WIN_SCORE      = 7,
  parameter int TIMEOUT_FRAMES = 300,
  parameter int P1_X           = 280,
  parameter int P2_X           = 340,
  parameter int DIGIT_Y        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       vsync,
  input  logic       p1score,
  input  logic       p2score,
  input  logic       start,
  output logic [3:0] p1_points,
  output logic [3:0] p2_points,
  output logic       game_over,
  output logic       winner,
  output logic       ball_hold,
  output logic       r,
  output logic       g,
  output logic       b,
  output logic [6:0] hex_p1,
  output logic [6:0] hex_p2
);

  typedef enum logic [1:0] {PLAY, GAME_OVER, RESTART} state_t;

  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [9:0] TIMEOUT = 10'(TIMEOUT_FRAMES);
  localparam logic       TMO_EN  = (TIMEOUT_FRAMES != 0);
  localparam logic [9:0] P1X     = 10'(P1_X);
  localparam logic [9:0] P1XE    = 10'(P1_X + 19);
  localparam logic [9:0] P2X     = 10'(P2_X);
  localparam logic [9:0] P2XE    = 10'(P2_X + 19);
  localparam logic [9:0] DY      = 10'(DIGIT_Y);
  localparam logic [9:0] DYE     = 10'(DIGIT_Y + 35);

  state_t     state, next_state;
  logic [2:0] p1_sh, p2_sh, st_sh;
  logic       p1_ev, p2_ev, start_ev;
  logic       vsync_d, frame_tick;
  logic [9:0] frame_cnt;
  logic       p1_win, p2_win, timeout_hit;
  logic       nr, ng, nb;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a decimal digit.
  function automatic logic [6:0] seg_on(input logic [3:0] v);
    case (v)
      4'd0:    seg_on = 7'h3F;
      4'd1:    seg_on = 7'h06;
      4'd2:    seg_on = 7'h5B;
      4'd3:    seg_on = 7'h4F;
      4'd4:    seg_on = 7'h66;
      4'd5:    seg_on = 7'h6D;
      4'd6:    seg_on = 7'h7D;
      4'd7:    seg_on = 7'h07;
      4'd8:    seg_on = 7'h7F;
      4'd9:    seg_on = 7'h6F;
      default: seg_on = 7'h00;
    endcase
  endfunction

  // Pixel test inside a 20x36 box; dx/dy are already known to be in the box.
  function automatic logic seg_hit(input logic [9:0] dx, input logic [9:0] dy,
                                   input logic [6:0] s);
    seg_hit = (s[0] && dy <= 10'd3)
           || (s[1] && dx >= 10'd16 && dy <= 10'd19)
           || (s[2] && dx >= 10'd16 && dy >= 10'd16)
           || (s[3] && dy >= 10'd32)
           || (s[4] && dx <= 10'd3  && dy >= 10'd16)
           || (s[5] && dx <= 10'd3  && dy <= 10'd19)
           || (s[6] && dy >= 10'd16 && dy <= 10'd19);
  endfunction

  // Two-flop synchronisers; bit 2 keeps the previous synchronised value so the
  // registered rising-edge pulse lands three cycles after the input rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_sh    <= '0;
      p2_sh    <= '0;
      st_sh    <= '0;
      p1_ev    <= 1'b0;
      p2_ev    <= 1'b0;
      start_ev <= 1'b0;
      vsync_d  <= 1'b0;
    end else begin
      p1_sh    <= {p1_sh[1:0], p1score};
      p2_sh    <= {p2_sh[1:0], p2score};
      st_sh    <= {st_sh[1:0], start};
      p1_ev    <= p1_sh[1] & ~p1_sh[2];
      p2_ev    <= p2_sh[1] & ~p2_sh[2];
      start_ev <= st_sh[1] & ~st_sh[2];
      vsync_d  <= vsync;
    end
  end

  assign frame_tick  = vsync_d & ~vsync;
  assign p1_win      = (p1_points == WIN);
  assign p2_win      = (p2_points == WIN);
  assign timeout_hit = TMO_EN && (frame_cnt == TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PLAY;
    else       state <= next_state;
  end

  // start_ev and the timeout share one exit, so start priority is implicit.
  always_comb begin
    next_state = state;
    case (state)
      PLAY:      if (p1_win || p2_win)         next_state = GAME_OVER;
      GAME_OVER: if (start_ev || timeout_hit)  next_state = RESTART;
      RESTART:   if (frame_tick)               next_state = PLAY;
      default:                                 next_state = PLAY;
    endcase
  end

  // Scoring freezes as soon as either side holds WIN, which also covers the
  // cycle between reaching WIN and entering GAME_OVER.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_points <= '0;
      p2_points <= '0;
      frame_cnt <= '0;
      winner    <= 1'b0;
    end else if (state == GAME_OVER && next_state == RESTART) begin
      p1_points <= '0;
      p2_points <= '0;
      frame_cnt <= '0;
    end else begin
      if (state == PLAY && !p1_win && !p2_win) begin
        if (p1_ev) p1_points <= p1_points + 4'd1;
        if (p2_ev) p2_points <= p2_points + 4'd1;
      end
      if (state == GAME_OVER && frame_tick) frame_cnt <= frame_cnt + 10'd1;
      if (state == PLAY && next_state == GAME_OVER) winner <= p2_win && !p1_win;
    end
  end

  assign game_over = (state == GAME_OVER);
  assign ball_hold = (state != PLAY);

  logic       in1, in2, lit1, lit2, lit_win, lit_lose;
  logic [9:0] dx1, dx2, dy;

  assign in1      = (hcount >= P1X) && (hcount <= P1XE) && (vcount >= DY) && (vcount <= DYE);
  assign in2      = (hcount >= P2X) && (hcount <= P2XE) && (vcount >= DY) && (vcount <= DYE);
  assign dx1      = hcount - P1X;
  assign dx2      = hcount - P2X;
  assign dy       = vcount - DY;
  assign lit1     = in1 && seg_hit(dx1, dy, seg_on(p1_points));
  assign lit2     = in2 && seg_hit(dx2, dy, seg_on(p2_points));
  assign lit_win  = winner ? lit2 : lit1;
  assign lit_lose = winner ? lit1 : lit2;

  // In GAME_OVER the loser is red and the winner flashes on frame_cnt bit 4.
  always_comb begin
    {nr, ng, nb} = 3'b000;
    if (state == GAME_OVER) begin
      if (lit_win && !frame_cnt[4]) {nr, ng, nb} = 3'b111;
      else if (lit_lose)            {nr, ng, nb} = 3'b100;
    end else if (lit1 || lit2) begin
      {nr, ng, nb} = 3'b111;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r, g, b} <= 3'b000;
      hex_p1    <= 7'b1000000;
      hex_p2    <= 7'b1000000;
    end else begin
      {r, g, b} <= {nr, ng, nb};
      hex_p1    <= ~seg_on(p1_points);
      hex_p2    <= ~seg_on(p2_points);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed bench for score_keeper.
//
// Two instances share all inputs: dut uses a 5-frame timeout, dut2 has the
// timeout disabled so it can stay in GAME_OVER long enough to show the flash.
// Render checks use a table of {hcount, vcount, rgb} records; the multi-cycle
// behaviours (synchroniser latency, win, timeout, restart) are hand sequences.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hcount, vcount;
  logic       vsync, p1score, p2score, start;

  logic [3:0] p1_points, p2_points, p1_points_2, p2_points_2;
  logic       game_over, winner, ball_hold, r, g, b;
  logic       game_over_2, winner_2, ball_hold_2, r_2, g_2, b_2;
  logic [6:0] hex_p1, hex_p2, hex_p1_2, hex_p2_2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] rgb;
  } vec_t;

  vec_t vecs[11];

  score_keeper #(.TIMEOUT_FRAMES(5)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .p1score(p1score), .p2score(p2score), .start(start),
    .p1_points(p1_points), .p2_points(p2_points), .game_over(game_over),
    .winner(winner), .ball_hold(ball_hold), .r(r), .g(g), .b(b),
    .hex_p1(hex_p1), .hex_p2(hex_p2)
  );

  score_keeper #(.TIMEOUT_FRAMES(0)) dut2 (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .p1score(p1score), .p2score(p2score), .start(start),
    .p1_points(p1_points_2), .p2_points(p2_points_2), .game_over(game_over_2),
    .winner(winner_2), .ball_hold(ball_hold_2), .r(r_2), .g(g_2), .b(b_2),
    .hex_p1(hex_p1_2), .hex_p2(hex_p2_2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One vsync high/low pair; frame_tick fires on the edge that ends this task.
  task automatic frame();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(1);
  endtask

  // Hold one point flag long enough to register, then let the synchroniser drain.
  task automatic point(input bit who);
    if (who) p2score = 1'b1;
    else     p1score = 1'b1;
    tick(6);
    p1score = 1'b0;
    p2score = 1'b0;
    tick(5);
  endtask

  task automatic applyStimulus(input string name, input vec_t v, input bit second);
    hcount = v.h;
    vcount = v.v;
    tick(1);
    if (second) checkOutput(name, {r_2, g_2, b_2}, v.rgb);
    else        checkOutput(name, {r, g, b}, v.rgb);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{10'd296, 10'd20, 3'b111};
    vecs[1]  = '{10'd281, 10'd20, 3'b000};
    vecs[2]  = '{10'd280, 10'd16, 3'b000};
    vecs[3]  = '{10'd299, 10'd51, 3'b111};
    vecs[4]  = '{10'd300, 10'd20, 3'b000};
    vecs[5]  = '{10'd296, 10'd15, 3'b000};
    vecs[6]  = '{10'd356, 10'd30, 3'b111};
    vecs[7]  = '{10'd296, 10'd52, 3'b000};
    vecs[8]  = '{10'd290, 10'd18, 3'b000};
    vecs[9]  = '{10'd340, 10'd20, 3'b000};
    vecs[10] = '{10'd359, 10'd40, 3'b111};

    reset = 1'b1; hcount = '0; vcount = '0; vsync = 1'b0;
    p1score = 1'b0; p2score = 1'b0; start = 1'b0;
    tick(3);
    checkOutput("rst_p1_points", p1_points, 4'd0);
    checkOutput("rst_p2_points", p2_points, 4'd0);
    checkOutput("rst_game_over", game_over, 1'b0);
    checkOutput("rst_winner",    winner,    1'b0);
    checkOutput("rst_ball_hold", ball_hold, 1'b0);
    checkOutput("rst_rgb",       {r, g, b}, 3'b000);
    checkOutput("rst_hex_p1",    hex_p1,    7'b1000000);
    checkOutput("rst_hex_p2",    hex_p2,    7'b1000000);

    // Reset arriving while a p1 flag is still inside the synchroniser.
    reset = 1'b0;
    p1score = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    p1score = 1'b0;
    checkOutput("midrst_p1_points", p1_points, 4'd0);
    checkOutput("midrst_hex_p1",    hex_p1,    7'b1000000);
    tick(2);
    reset = 1'b0;
    tick(8);
    checkOutput("midrst_p1_after", p1_points, 4'd0);

    // Single p2 point: visible 4 edges after the rise, hex one edge later.
    p2score = 1'b1;
    tick(3);
    checkOutput("p2_not_yet", p2_points, 4'd0);
    tick(1);
    checkOutput("p2_counted", p2_points, 4'd1);
    checkOutput("hex_p2_lag", hex_p2, 7'b1000000);
    tick(1);
    checkOutput("hex_p2_one", hex_p2, 7'b1111001);
    tick(20);
    checkOutput("p2_once", p2_points, 4'd1);
    p2score = 1'b0;
    tick(5);

    point(1'b0);
    checkOutput("p1_one", p1_points, 4'd1);
    checkOutput("hex_p1_one", hex_p1, 7'b1111001);

    for (int i = 0; i < 11; i++)
      applyStimulus($sformatf("render_%0d", i), vecs[i], 1'b0);

    // Both to 6, then simultaneous winning points.
    repeat (5) point(1'b0);
    repeat (5) point(1'b1);
    checkOutput("p1_six", p1_points, 4'd6);
    checkOutput("p2_six", p2_points, 4'd6);
    p1score = 1'b1;
    p2score = 1'b1;
    tick(4);
    checkOutput("sim_p1_seven", p1_points, 4'd7);
    checkOutput("sim_p2_seven", p2_points, 4'd7);
    checkOutput("sim_go_next",  game_over, 1'b0);
    tick(1);
    checkOutput("sim_game_over", game_over, 1'b1);
    checkOutput("sim_winner",    winner,    1'b0);
    checkOutput("sim_ball_hold", ball_hold, 1'b1);
    checkOutput("sim_winner_2",  winner_2,  1'b0);
    p1score = 1'b0;
    p2score = 1'b0;
    tick(5);
    checkOutput("hex_p1_seven", hex_p1, 7'b1111000);

    applyStimulus("go_winner_b",   '{10'd296, 10'd20, 3'b111}, 1'b0);
    applyStimulus("go_loser_red",  '{10'd356, 10'd20, 3'b100}, 1'b0);
    applyStimulus("go_winner_a",   '{10'd290, 10'd18, 3'b111}, 1'b0);

    point(1'b1);
    checkOutput("go_p2_frozen", p2_points, 4'd7);
    point(1'b0);
    checkOutput("go_p1_frozen", p1_points, 4'd7);

    // Timeout on dut after the 5th frame tick; dut2 never times out.
    repeat (4) frame();
    tick(3);
    checkOutput("tmo_four_frames", game_over, 1'b1);
    frame();
    checkOutput("tmo_fifth_edge", game_over, 1'b1);
    tick(1);
    checkOutput("tmo_restart_go",   game_over, 1'b0);
    checkOutput("tmo_restart_hold", ball_hold, 1'b1);
    checkOutput("tmo_restart_p1",   p1_points, 4'd0);
    checkOutput("tmo_dut2_stays",   game_over_2, 1'b1);

    // Winner flash on dut2: counter 15 white, 16 blank, 31 blank, 32 white.
    repeat (10) frame();
    applyStimulus("flash_15", '{10'd296, 10'd20, 3'b111}, 1'b1);
    frame();
    applyStimulus("flash_16", '{10'd296, 10'd20, 3'b000}, 1'b1);
    checkOutput("dut_play_digit0", {r, g, b}, 3'b111);
    applyStimulus("flash_16_loser", '{10'd356, 10'd20, 3'b100}, 1'b1);
    repeat (15) frame();
    applyStimulus("flash_31", '{10'd296, 10'd20, 3'b000}, 1'b1);
    frame();
    applyStimulus("flash_32", '{10'd296, 10'd20, 3'b111}, 1'b1);

    // Restart dut2 with start; ball_hold waits for the next frame tick.
    start = 1'b1;
    tick(3);
    checkOutput("start_not_yet", game_over_2, 1'b1);
    tick(1);
    checkOutput("start_go",   game_over_2, 1'b0);
    checkOutput("start_p1",   p1_points_2, 4'd0);
    checkOutput("start_p2",   p2_points_2, 4'd0);
    checkOutput("start_hold", ball_hold_2, 1'b1);
    start = 1'b0;
    tick(10);
    checkOutput("start_hold_wait", ball_hold_2, 1'b1);
    frame();
    checkOutput("start_hold_drop", ball_hold_2, 1'b0);
    point(1'b0);
    checkOutput("restart_counts", p1_points_2, 4'd1);

    // Player 2 wins alone.
    repeat (7) point(1'b1);
    checkOutput("p2win_points", p2_points_2, 4'd7);
    checkOutput("p2win_go",     game_over_2, 1'b1);
    checkOutput("p2win_winner", winner_2,    1'b1);
    checkOutput("p2win_p1",     p1_points_2, 4'd1);
    checkOutput("p2win_hex",    hex_p2_2,    7'b1111000);
    checkOutput("p2win_dut",    winner,      1'b1);
    point(1'b1);
    checkOutput("p2win_sat",    p2_points_2, 4'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Downstream of the ball stage. Consumes the ball's p1score/p2score point flags and counts points per player.
- Runs the match state machine (play / game over / restart) and holds the ball in reset between matches.
- Draws both scores as 7-segment-style digits in the top of the 640x480 frame and drives the board HEX displays.
- Sits between the ball stage and the top-level RGB OR-mixer.

Parameters:
- WIN_SCORE, 7, points needed to win a match; legal range 1..9.
- TIMEOUT_FRAMES, 300, frames in GAME_OVER before automatic restart; 0 disables the timeout.
- P1_X, 280, left x of the player-1 digit box.
- P2_X, 340, left x of the player-2 digit box.
- DIGIT_Y, 16, top y of both digit boxes.

Ports:
- clk  in  1  pixel clock, same clock as the hcount/vcount source
- reset  in  1  asynchronous, active-high
- hcount  in  10  current pixel x
- vcount  in  10  current pixel y
- vsync  in  1  VGA vsync, synchronous to clk
- p1score  in  1  ball-stage point flag for player 1; level, asynchronous to clk
- p2score  in  1  ball-stage point flag for player 2; level, asynchronous to clk
- start  in  1  serve/restart button, active-high, asynchronous
- p1_points  out  4  player-1 score, binary
- p2_points  out  4  player-2 score, binary
- game_over  out  1  high in GAME_OVER
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over is high
- ball_hold  out  1  level; the top level ORs it into the ball stage reset
- r, g, b  out  1 each  score overlay pixel, registered
- hex_p1  out  7  active-low segments {g,f,e,d,c,b,a} for p1_points
- hex_p2  out  7  active-low segments for p2_points

Behaviour:
- Reset is asynchronous, active-high; clock clk. All flops are cleared by reset.
- Reset values: state=PLAY, p1_points=p2_points=0, game_over=0, winner=0, ball_hold=0, r=g=b=0, hex_p1=hex_p2=7'b1000000 ("0"), frame counter=0.
- Synchronisers: p1score, p2score and start each pass through a 2-flop synchroniser, then a rising-edge detector. This gives 1-cycle pulses p1_ev, p2_ev, start_ev, each 3 cycles after the input rises.
- frame_tick is a 1-cycle pulse on the clk edge where vsync was 1 last cycle and is 0 now.
- State PLAY:
  - p1_ev increments p1_points; p2_ev increments p2_points. Simultaneous events increment both.
  - A score that becomes WIN_SCORE moves the state to GAME_OVER on the next cycle, with game_over=1 and ball_hold=1.
  - winner is the player who reached WIN_SCORE. If both reach it in the same cycle, winner=0.
  - start_ev is ignored in PLAY.
- State GAME_OVER:
  - Score events are ignored; counters never exceed WIN_SCORE.
  - The frame counter increments on each frame_tick.
  - Exit to RESTART on start_ev, or when the frame counter reaches TIMEOUT_FRAMES (if TIMEOUT_FRAMES is non-zero). start_ev wins if both occur in the same cycle.
- State RESTART:
  - On entry: scores and frame counter are cleared, game_over=0, ball_hold stays 1.
  - On the next frame_tick: go to PLAY and drop ball_hold.
- A reset asserted mid-match clears everything; the in-flight synchroniser contents are discarded.
- Rendering, 1-cycle latency from hcount/vcount:
  - Each digit box is 20 wide x 36 tall, segment thickness 4. Offsets are relative to the box origin (bx, by).
  - a: y 0..3, all x.
  - b: x 16..19, y 0..19.
  - c: x 16..19, y 16..35.
  - d: y 32..35, all x.
  - e: x 0..3, y 16..35.
  - f: x 0..3, y 0..19.
  - g: y 16..19, all x.
  - A pixel is lit when it lies inside the box and inside any segment that is on for that digit's value. Segment decoding is shared with the HEX outputs.
  - Lit pixel in PLAY or RESTART: r=g=b=1.
  - Lit pixel in GAME_OVER: the loser's digit shows r=1, g=b=0. The winner's digit shows white while frame counter bit 4 is 0 and is blank while it is 1 (flash period 32 frames).
  - Pixels outside both boxes: r=g=b=0.
  - Comparisons use 10-bit unsigned arithmetic; the box edges are inclusive.
- hex_p1/hex_p2 are registered decodes of the counters, valid 1 cycle after a counter change.

Test Plan:
- Reset mid-operation: drive p1score high, assert reset -> all outputs equal their reset values; p1_points stays 0 after release.
- Single point: pulse p2score high for 2 frames -> p2_points=1 exactly once, 4 cycles after the rise; hex_p2=7'b1111001.
- Simultaneous points: p1score and p2score rise on the same clk edge, each side at 6 with WIN_SCORE=7 -> both scores read 7, game_over=1, winner=0, ball_hold=1.
- Win then restart: p1 reaches 7 -> GAME_OVER. Pulse start -> scores read 0 and game_over=0 immediately; ball_hold stays 1 until the next vsync falling edge, then drops to 0 and further score events count again.
- Timeout: TIMEOUT_FRAMES=5, in GAME_OVER with no start -> state is RESTART after the 5th vsync falling edge.
- Render: p1_points=1, hcount=296, vcount=20 -> r=g=b=1 one cycle later. hcount=281, vcount=20 -> 0. Winner digit in GAME_OVER is blank while the frame counter is in 16..31.
